// File: rtl/char_motion_ctrl.sv
// Frame-ticked motion and state engine for one player character: walking, jumping,
// gravity, landing on a per-frame ground level, knockback with i-frames, and death.
module char_motion_ctrl #(
  parameter int SCREEN_W      = 1024,
  parameter int CHAR_W        = 64,
  parameter int CHAR_H        = 64,
  parameter int X_START       = 100,
  parameter int GROUND_Y      = 700,
  parameter int STEP          = 4,
  parameter int JUMP_V0       = 18,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 16,
  parameter int KNOCK_FRAMES  = 8,
  parameter int KNOCK_STEP    = 6,
  parameter int INVULN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [1:0]  game_active,
  input  logic        game_start,
  input  logic        stepleft,
  input  logic        stepright,
  input  logic        stepjump,
  input  logic [11:0] ground_lvl,
  input  logic        hit,
  input  logic        hit_from_left,
  input  logic        hp_zero,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic        flip_h,
  output logic        airborne,
  output logic        invuln,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WALK  = 3'd1,
    ST_JUMP  = 3'd2,
    ST_FALL  = 3'd3,
    ST_KNOCK = 3'd4,
    ST_DEAD  = 3'd5
  } state_e;

  localparam int IW = $clog2(INVULN_FRAMES + 1);
  localparam int KW = $clog2(KNOCK_FRAMES + 1);

  localparam logic signed [12:0] XMAX_S  = 13'(SCREEN_W - CHAR_W);
  localparam logic signed [12:0] CH_S    = 13'(CHAR_H);
  localparam logic signed [12:0] STEP_S  = 13'(STEP);
  localparam logic signed [12:0] KSTEP_S = 13'(KNOCK_STEP);
  localparam logic signed [12:0] JV0_S   = 13'(JUMP_V0);
  localparam logic signed [12:0] GRAV_S  = 13'(GRAVITY);
  localparam logic signed [12:0] MAXF_S  = 13'(MAX_FALL);
  localparam logic [11:0]        XSTART  = 12'(X_START);
  localparam logic [11:0]        YSTART  = 12'(GROUND_Y - CHAR_H);
  localparam logic signed [7:0]  KNOCK_VY = 8'(-(JUMP_V0 / 2));
  localparam logic [IW-1:0]      INV_LOAD = IW'(INVULN_FRAMES);
  localparam logic [KW-1:0]      KNK_LOAD = KW'(KNOCK_FRAMES);

  state_e                state_q, state_d;
  logic [11:0]           pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [7:0]     vel_y_q, vel_y_d;
  logic                  flip_q, flip_d;
  logic [IW-1:0]         invuln_q, invuln_d;
  logic [KW-1:0]         knock_q, knock_d;
  logic                  hit_lat_q, hit_lat_d;
  logic                  hit_dir_q, hit_dir_d;
  logic                  knock_dir_q, knock_dir_d;

  logic                  grounded, move_l, move_r, moving, air_land;
  logic signed [12:0]    pos_x_s, pos_y_s, gnd_s, vel_s, vin_s, ny_s, dx_s, nx_s, kx_s;
  logic signed [12:0]    vinc_s, air_y_s, air_vel_s;

  function automatic logic [11:0] clampX(input logic signed [12:0] v);
    if (v < 13'sd0)        return 12'd0;
    else if (v > XMAX_S)   return XMAX_S[11:0];
    else                   return v[11:0];
  endfunction

  assign grounded = (state_q == ST_IDLE) || (state_q == ST_WALK);
  assign move_l   = stepleft & ~stepright;
  assign move_r   = stepright & ~stepleft;
  assign moving   = move_l | move_r;

  assign pos_x_s = $signed({1'b0, pos_x_q});
  assign pos_y_s = $signed({1'b0, pos_y_q});
  assign gnd_s   = $signed({1'b0, ground_lvl});
  assign vel_s   = $signed({{5{vel_y_q[7]}}, vel_y_q});
  assign dx_s    = move_l ? -STEP_S : (move_r ? STEP_S : 13'sd0);
  assign nx_s    = pos_x_s + dx_s;
  assign kx_s    = pos_x_s + (knock_dir_q ? KSTEP_S : -KSTEP_S);

  // Grounded states only reach the vertical path when launching a jump
  assign vin_s  = grounded ? -JV0_S : vel_s;
  assign ny_s   = pos_y_s + vin_s;
  assign vinc_s = vin_s + GRAV_S;

  always_comb begin
    air_land  = 1'b0;
    air_y_s   = ny_s;
    air_vel_s = (vinc_s > MAXF_S) ? MAXF_S : vinc_s;
    if ((vin_s >= 13'sd0) && (ny_s + CH_S >= gnd_s)) begin
      air_land  = 1'b1;
      air_y_s   = gnd_s - CH_S;
      air_vel_s = 13'sd0;
    end else if ((vin_s < 13'sd0) && (ny_s <= 13'sd0)) begin
      air_y_s   = 13'sd0;
      air_vel_s = 13'sd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    vel_y_d     = vel_y_q;
    flip_d      = flip_q;
    invuln_d    = invuln_q;
    knock_d     = knock_q;
    knock_dir_d = knock_dir_q;
    hit_lat_d   = hit_lat_q | hit;
    hit_dir_d   = hit ? hit_from_left : hit_dir_q;

    if (game_start) begin
      state_d     = ST_IDLE;
      pos_x_d     = XSTART;
      pos_y_d     = YSTART;
      vel_y_d     = 8'sd0;
      flip_d      = 1'b0;
      invuln_d    = '0;
      knock_d     = '0;
      hit_lat_d   = 1'b0;
    end else if (frame_tick && (game_active == 2'd1)) begin
      // The latch is consumed here; a hit on this very cycle waits for the next frame
      hit_lat_d = hit;
      invuln_d  = (invuln_q != '0) ? invuln_q - IW'(1) : '0;

      if (hp_zero || (state_q == ST_DEAD)) begin
        state_d = ST_DEAD;
        vel_y_d = 8'sd0;
      end else if (hit_lat_q && (invuln_q == '0)) begin
        state_d     = ST_KNOCK;
        knock_d     = KNK_LOAD;
        invuln_d    = INV_LOAD;
        vel_y_d     = KNOCK_VY;
        knock_dir_d = hit_dir_q;
      end else begin
        case (state_q)
          ST_KNOCK: begin
            pos_x_d = clampX(kx_s);
            pos_y_d = air_y_s[11:0];
            vel_y_d = air_vel_s[7:0];
            knock_d = knock_q - KW'(1);
            if (knock_q <= KW'(1))
              state_d = (air_y_s + CH_S < gnd_s) ? ST_FALL : ST_IDLE;
          end
          ST_JUMP, ST_FALL: begin
            pos_x_d = clampX(nx_s);
            if (move_l) flip_d = 1'b1;
            if (move_r) flip_d = 1'b0;
            pos_y_d = air_y_s[11:0];
            vel_y_d = air_vel_s[7:0];
            if (air_land)
              state_d = moving ? ST_WALK : ST_IDLE;
            else if (air_vel_s >= 13'sd0)
              state_d = ST_FALL;
          end
          default: begin
            pos_x_d = clampX(nx_s);
            if (move_l) flip_d = 1'b1;
            if (move_r) flip_d = 1'b0;
            if (stepjump) begin
              pos_y_d = air_y_s[11:0];
              vel_y_d = air_vel_s[7:0];
              state_d = (air_vel_s >= 13'sd0) ? ST_FALL : ST_JUMP;
            end else if (pos_y_s + CH_S < gnd_s) begin
              state_d = ST_FALL;
              vel_y_d = 8'sd0;
            end else begin
              // Also covers the ground being raised under a standing character
              pos_y_d = 12'(gnd_s - CH_S);
              vel_y_d = 8'sd0;
              state_d = moving ? ST_WALK : ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pos_x_q     <= XSTART;
      pos_y_q     <= YSTART;
      vel_y_q     <= 8'sd0;
      flip_q      <= 1'b0;
      invuln_q    <= '0;
      knock_q     <= '0;
      hit_lat_q   <= 1'b0;
      hit_dir_q   <= 1'b0;
      knock_dir_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      vel_y_q     <= vel_y_d;
      flip_q      <= flip_d;
      invuln_q    <= invuln_d;
      knock_q     <= knock_d;
      hit_lat_q   <= hit_lat_d;
      hit_dir_q   <= hit_dir_d;
      knock_dir_q <= knock_dir_d;
    end
  end

  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign flip_h   = flip_q;
  assign airborne = (state_q == ST_JUMP) || (state_q == ST_FALL);
  assign invuln   = (invuln_q != '0);
  assign state    = state_q;

endmodule
